// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch request bus between the PC unit and instruction memory
interface pc_fetch_unit_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus;
    logic            fetch_valid;
    logic            fetch_ready;
    modport master (output pc, pc_plus, fetch_valid, input fetch_ready);
    modport slave  (input pc, pc_plus, fetch_valid, output fetch_ready);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage program counter with fetch handshake, prioritised redirects and return-address stack
module pc_fetch_unit #(
    parameter int              PC_W      = 32,
    parameter int              STEP      = 1,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              JIDX_W    = 26,
    parameter int              RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_cond,
    input  logic               alu_zero,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump,
    input  logic               call,
    input  logic [JIDX_W-1:0]  jump_idx,
    input  logic               ret,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    pc_fetch_unit_if.master    fif,
    output logic               ras_empty,
    output logic               ras_overflow,
    output logic               ras_underflow
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_plus, ras_top;
    logic [PC_W-1:0]   ras_q [RAS_DEPTH];
    logic [PC_W-1:0]   ras_d [RAS_DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d, ptr_inc;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              active, br_tk, ev, accept, empty, full, push, pop, repl, stack_op;

    always_comb begin
        pc_plus  = pc_q + PC_W'(STEP);
        active   = state_q != BOOT;
        br_tk    = branch_cond & alu_zero;
        ev       = active & (redirect | ret | jump | call | br_tk);
        accept   = (state_q == FETCH) & fif.fetch_ready;
        empty    = cnt_q == '0;
        full     = cnt_q == CW'(RAS_DEPTH);
        ras_top  = ras_q[ptr_q];
        ptr_inc  = ptr_q + 1'b1;
        pc_d     = ~active          ? pc_q :
                   redirect         ? redirect_pc :
                   ret              ? (empty ? pc_plus : ras_top) :
                   (jump | call)    ? {pc_plus[PC_W-1:JIDX_W], jump_idx} :
                   br_tk            ? branch_target :
                   (accept & ~stall)? pc_plus : pc_q;
        state_d  = (state_q == BOOT) ? FETCH : (stall & ~ev) ? HOLD : FETCH;
        // a redirect overrides the stack side effects of call/ret entirely
        stack_op = active & ~redirect;
        push     = stack_op & call & (~ret | empty);
        pop      = stack_op & ret & ~call & ~empty;
        repl     = stack_op & ret & call & ~empty;
        ras_d    = ras_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (push & full);
        unf_d    = unf_q | (stack_op & ret & empty);
        if (push) begin
            ptr_d          = ptr_inc;
            ras_d[ptr_inc] = pc_plus;
            cnt_d          = full ? cnt_q : cnt_q + 1'b1;
        end
        if (pop) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
        if (repl) ras_d[ptr_q] = pc_plus;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ras_q   <= '{default: '0};
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ras_q   <= ras_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign fif.pc          = pc_q;
    assign fif.pc_plus     = pc_plus;
    assign fif.fetch_valid = state_q == FETCH;
    assign ras_empty       = empty;
    assign ras_overflow    = ovf_q;
    assign ras_underflow   = unf_q;
endmodule
